// File: rtl/shift_decode_stage.sv
// Decode/issue stage for MIPS R-type shifts into the shift/rotate unit.
// Define SHIFT_DECODE_ROTATE_EN to decode ROTR/ROTRV/ROTL/ROTLV.
module shift_decode_stage #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          inst,
  input  logic [31:0]          rsVal,
  input  logic [31:0]          rtVal,
  input  logic                 inValid,
  output logic                 inReady,
  output logic [31:0]          aShiftRotate,
  output logic [4:0]           bShiftRotate,
  output logic [2:0]           opcodeShiftRotate,
  output logic [4:0]           rdOut,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] illegalCount
);

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  b;
    logic [2:0]  op;
    logic [4:0]  rd;
  } sd_t;

  localparam sd_t SD_RST = '{
    a:  32'd0,
    b:  5'd0,
    op: OP_SLL,
    rd: 5'd0
  };

  logic [5:0] funct;
  logic [4:0] rsf;
  logic [4:0] sh;
  logic       top_ok;
  logic       rs_z;
  logic       sh_z;
  logic       f_sll;
  logic       f_srl;
  logic       f_sra;
  logic       f_sllv;
  logic       f_srlv;
  logic       f_srav;
`ifdef SHIFT_DECODE_ROTATE_EN
  logic       rs_one;
  logic       sh_one;
  logic       f_rotl;
  logic       f_rotlv;
`endif

  logic       dec_legal;
  logic [2:0] dec_op;
  logic [4:0] dec_b;
  sd_t        dec;

  sd_t        out_q;
  sd_t        out_n;
  logic       out_v;
  logic       out_v_n;
  sd_t        skid_q;
  sd_t        skid_n;
  logic       skid_v;
  logic       skid_v_n;
  logic       rdy_q;

  logic       accept;
  logic       acc_ok;
  logic       acc_bad;
  logic       drain;

  logic       ill_q;
  logic [ILL_CNT_W-1:0] cnt_q;

  logic       unused_bits;

  assign funct  = inst[5:0];
  assign rsf    = inst[25:21];
  assign sh     = inst[10:6];
  assign top_ok = (inst[31:26] == 6'd0);
  assign rs_z   = (rsf == 5'd0);
  assign sh_z   = (sh == 5'd0);

  assign f_sll  = (funct == 6'b000000);
  assign f_srl  = (funct == 6'b000010);
  assign f_sra  = (funct == 6'b000011);
  assign f_sllv = (funct == 6'b000100);
  assign f_srlv = (funct == 6'b000110);
  assign f_srav = (funct == 6'b000111);
`ifdef SHIFT_DECODE_ROTATE_EN
  assign rs_one  = (rsf == 5'd1);
  assign sh_one  = (sh == 5'd1);
  assign f_rotl  = (funct == 6'b000001);
  assign f_rotlv = (funct == 6'b000101);
`endif

  assign unused_bits = ^{inst[20:16], rsVal[31:5]};

  // Field decode: opcode, amount source and legality of the offered word.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_SLL;
    dec_b     = sh;
    unique case (1'b1)
      f_sll: begin
        dec_legal = rs_z;
        dec_op    = OP_SLL;
      end
      f_srl: begin
        if (rs_z) begin
          dec_legal = 1'b1;
          dec_op    = OP_SRL;
        end
`ifdef SHIFT_DECODE_ROTATE_EN
        else if (rs_one) begin
          dec_legal = 1'b1;
          dec_op    = OP_ROR;
        end
`endif
      end
      f_sra: begin
        dec_legal = rs_z;
        dec_op    = OP_SRA;
      end
      f_sllv: begin
        dec_legal = sh_z;
        dec_op    = OP_SLL;
        dec_b     = rsVal[4:0];
      end
      f_srlv: begin
        dec_b = rsVal[4:0];
        if (sh_z) begin
          dec_legal = 1'b1;
          dec_op    = OP_SRL;
        end
`ifdef SHIFT_DECODE_ROTATE_EN
        else if (sh_one) begin
          dec_legal = 1'b1;
          dec_op    = OP_ROR;
        end
`endif
      end
      f_srav: begin
        dec_legal = sh_z;
        dec_op    = OP_SRA;
        dec_b     = rsVal[4:0];
      end
`ifdef SHIFT_DECODE_ROTATE_EN
      f_rotl: begin
        dec_legal = rs_z;
        dec_op    = OP_ROL;
      end
      f_rotlv: begin
        dec_legal = sh_z;
        dec_op    = OP_ROL;
        dec_b     = rsVal[4:0];
      end
`endif
      default: begin
        dec_legal = 1'b0;
      end
    endcase
    if (!top_ok) begin
      dec_legal = 1'b0;
    end
  end

  assign dec = '{
    a:  rtVal,
    b:  dec_b,
    op: dec_op,
    rd: inst[15:11]
  };

  assign accept  = inValid && rdy_q;
  assign acc_ok  = accept && dec_legal;
  assign acc_bad = accept && !dec_legal;
  assign drain   = out_v && outReady;

  // Two-entry buffer steering; skid is only written while output is held.
  always_comb begin
    out_n    = out_q;
    out_v_n  = out_v;
    skid_n   = skid_q;
    skid_v_n = skid_v;
    if (drain) begin
      if (skid_v) begin
        out_n    = skid_q;
        out_v_n  = 1'b1;
        skid_v_n = 1'b0;
      end else if (acc_ok) begin
        out_n   = dec;
        out_v_n = 1'b1;
      end else begin
        out_v_n = 1'b0;
      end
    end else if (!out_v) begin
      if (acc_ok) begin
        out_n   = dec;
        out_v_n = 1'b1;
      end
    end else if (acc_ok) begin
      skid_n   = dec;
      skid_v_n = 1'b1;
    end
  end

  // Buffer state and registered ready (ready = skid will be empty).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= SD_RST;
      out_v  <= 1'b0;
      skid_q <= SD_RST;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      out_q  <= out_n;
      out_v  <= out_v_n;
      skid_q <= skid_n;
      skid_v <= skid_v_n;
      rdy_q  <= !skid_v_n;
    end
  end

  // Illegal pulse and saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ill_q <= acc_bad;
      if (acc_bad && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign inReady           = rdy_q;
  assign outValid          = out_v;
  assign aShiftRotate      = out_q.a;
  assign bShiftRotate      = out_q.b;
  assign opcodeShiftRotate = out_q.op;
  assign rdOut             = out_q.rd;
  assign illegal           = ill_q;
  assign illegalCount      = cnt_q;

endmodule

// File: tb/tb_shift_decode_stage.sv
// Scoreboard bench for shift_decode_stage.
// Rotate expectations follow SHIFT_DECODE_ROTATE_EN.
module tb_shift_decode_stage;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SHIFT_DECODE_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [31:0]   inst;
  logic [31:0]   rsVal;
  logic [31:0]   rtVal;
  logic          inValid;
  logic          inReady;
  logic [31:0]   aShiftRotate;
  logic [4:0]    bShiftRotate;
  logic [2:0]    opcodeShiftRotate;
  logic [4:0]    rdOut;
  logic          outValid;
  logic          outReady;
  logic          illegal;
  logic [CW-1:0] illegalCount;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  bit last_legal;
  logic [44:0] sb[$];
  logic [44:0] mon_exp;
  logic [44:0] obs;

  shift_decode_stage #(.ILL_CNT_W(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .inst              (inst),
    .rsVal             (rsVal),
    .rtVal             (rtVal),
    .inValid           (inValid),
    .inReady           (inReady),
    .aShiftRotate      (aShiftRotate),
    .bShiftRotate      (bShiftRotate),
    .opcodeShiftRotate (opcodeShiftRotate),
    .rdOut             (rdOut),
    .outValid          (outValid),
    .outReady          (outReady),
    .illegal           (illegal),
    .illegalCount      (illegalCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {aShiftRotate, bShiftRotate, opcodeShiftRotate, rdOut};

  // Reference decode: {a, b, op, rd}
  function automatic void model(input logic [31:0] i, input logic [31:0] rs,
                                input logic [31:0] rt, output bit legal,
                                output logic [44:0] e);
    logic [2:0] op;
    logic [4:0] b;
    logic [4:0] rsf;
    logic [4:0] sh;
    rsf = i[25:21];
    sh = i[10:6];
    legal = 1'b0;
    op = 3'b010;
    b = sh;
    if (i[31:26] == 6'd0) begin
      case (i[5:0])
        6'd0: if (rsf == 0) begin legal = 1; op = 3'b010; end
        6'd2: begin
          if (rsf == 0) begin legal = 1; op = 3'b011; end
          else if (rsf == 1 && ROT) begin legal = 1; op = 3'b001; end
        end
        6'd3: if (rsf == 0) begin legal = 1; op = 3'b111; end
        6'd4: if (sh == 0) begin legal = 1; op = 3'b010; b = rs[4:0]; end
        6'd6: begin
          b = rs[4:0];
          if (sh == 0) begin legal = 1; op = 3'b011; end
          else if (sh == 1 && ROT) begin legal = 1; op = 3'b001; end
        end
        6'd7: if (sh == 0) begin legal = 1; op = 3'b111; b = rs[4:0]; end
        6'd1: if (ROT && rsf == 0) begin legal = 1; op = 3'b000; end
        6'd5: if (ROT && sh == 0) begin legal = 1; op = 3'b000; b = rs[4:0]; end
        default: legal = 1'b0;
      endcase
    end
    e = {rt, b, op, i[15:11]};
  endfunction

  // Scoreboard: every drained output must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && outValid && outReady) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output got=%h required=none", obs);
      end else begin
        mon_exp = sb.pop_front();
        if (obs !== mon_exp) begin
          n_err++;
          $display("FAIL sb_output got=%h required=%h", obs, mon_exp);
        end
      end
    end
  end

  // Offer one instruction; returns 1 time unit after its accepting edge.
  task automatic send(input logic [31:0] i, input logic [31:0] rs,
                      input logic [31:0] rt);
    bit lg;
    logic [44:0] e;
    int w;
    inst = i;
    rsVal = rs;
    rtVal = rt;
    inValid = 1'b1;
    w = 0;
    while (!inReady && w < 64) begin
      @(posedge clk); #1;
      w++;
    end
    if (!inReady) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout inReady=%b required=1", inReady);
      inValid = 1'b0;
      return;
    end
    model(i, rs, rt, lg, e);
    last_legal = lg;
    if (lg) sb.push_back(e);
    else exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int w;
    inValid = 1'b0;
    outReady = 1'b1;
    w = 0;
    while ((sb.size() != 0 || outValid) && w < 64) begin
      @(posedge clk); #1;
      w++;
    end
    n_cmp++;
    if (sb.size() != 0 || outValid !== 1'b0) begin
      n_err++;
      $display("FAIL drain pending=%0d outValid=%b required=0/0",
               sb.size(), outValid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inst = '0; rsVal = '0; rtVal = '0;
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({outValid, inReady, illegal} !== 3'b010) begin
      n_err++;
      $display("FAIL reset_flags got=%b required=010",
               {outValid, inReady, illegal});
    end
    n_cmp++;
    if (illegalCount !== '0) begin
      n_err++;
      $display("FAIL reset_count got=%0d required=0", illegalCount);
    end
    n_cmp++;
    if (obs !== {32'd0, 5'd0, 3'b010, 5'd0}) begin
      n_err++;
      $display("FAIL reset_fields got=%h required=%h", obs,
               {32'd0, 5'd0, 3'b010, 5'd0});
    end
  endtask

  task automatic test_sll();
    send(32'h0003_1080, 32'h0, 32'h1);
    inValid = 1'b0;
    n_cmp++;
    if (outValid !== 1'b1 ||
        obs !== {32'h1, 5'd2, 3'b010, 5'd2}) begin
      n_err++;
      $display("FAIL sll v=%b got=%h required=%h", outValid, obs,
               {32'h1, 5'd2, 3'b010, 5'd2});
    end
    wait_drain();
  endtask

  task automatic test_srav();
    send(32'h0064_2807, 32'hFFFF_FFE3, 32'h8000_0000);
    inValid = 1'b0;
    n_cmp++;
    if (outValid !== 1'b1 ||
        obs !== {32'h8000_0000, 5'd3, 3'b111, 5'd5}) begin
      n_err++;
      $display("FAIL srav v=%b got=%h required=%h", outValid, obs,
               {32'h8000_0000, 5'd3, 3'b111, 5'd5});
    end
    wait_drain();
  endtask

  task automatic test_rotr();
    send(32'h0022_1902, 32'h0, 32'hDEAD_BEEF);
    inValid = 1'b0;
    n_cmp++;
    if (ROT) begin
      if (outValid !== 1'b1 || illegal !== 1'b0 ||
          obs !== {32'hDEAD_BEEF, 5'd4, 3'b001, 5'd3}) begin
        n_err++;
        $display("FAIL rotr v=%b ill=%b got=%h required=%h", outValid,
                 illegal, obs, {32'hDEAD_BEEF, 5'd4, 3'b001, 5'd3});
      end
    end else begin
      if (outValid !== 1'b0 || illegal !== 1'b1 || illegalCount !== 8'd1) begin
        n_err++;
        $display("FAIL rotr_off v=%b ill=%b cnt=%0d required=0/1/1",
                 outValid, illegal, illegalCount);
      end
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] i1, i2, i3;
    bit lg;
    logic [44:0] e1;
    i1 = 32'h0000_2080;
    i2 = 32'h0000_3103;
    i3 = 32'h0000_4004;
    model(i1, 32'h0, 32'h1111_1111, lg, e1);
    outReady = 1'b0;
    send(i1, 32'h0, 32'h1111_1111);
    send(i2, 32'h0, 32'h2222_2222);
    n_cmp++;
    if (inReady !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready got=%b required=0", inReady);
    end
    inst = i3;
    rsVal = 32'h7;
    rtVal = 32'h3333_3333;
    inValid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if (inReady !== 1'b0 || outValid !== 1'b1 || obs !== e1) begin
        n_err++;
        $display("FAIL bp_hold rdy=%b v=%b got=%h required=0/1/%h",
                 inReady, outValid, obs, e1);
      end
    end
    outReady = 1'b1;
    send(i3, 32'h7, 32'h3333_3333);
    wait_drain();
  endtask

  task automatic test_random();
    logic [31:0] i;
    int p;
    for (int k = 0; k < 200; k++) begin
      p = $urandom_range(0, 9);
      i = $urandom;
      i[5:0] = (p < 8) ? p[5:0] : i[5:0];
      if ($urandom % 8 != 0) i[31:26] = 6'd0;
      case ($urandom % 3)
        0: i[25:21] = 5'd0;
        1: i[25:21] = 5'd1;
        default: ;
      endcase
      case ($urandom % 3)
        0: i[10:6] = 5'd0;
        1: i[10:6] = 5'd1;
        default: ;
      endcase
      outReady = ($urandom % 4 != 0) || !inReady;
      send(i, $urandom, $urandom);
      n_cmp++;
      if (illegal !== !last_legal || illegalCount !== exp_cnt[CW-1:0]) begin
        n_err++;
        $display("FAIL rand_illegal ill=%b cnt=%0d required=%b/%0d",
                 illegal, illegalCount, !last_legal, exp_cnt);
      end
    end
    wait_drain();
  endtask

  task automatic test_illegal_stream();
    outReady = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send(32'h2000_0000 | (k & 32'h3F), k, k);
      n_cmp++;
      if (illegal !== 1'b1 || outValid !== 1'b0 ||
          illegalCount !== exp_cnt[CW-1:0]) begin
        n_err++;
        $display("FAIL ill_stream k=%0d ill=%b v=%b cnt=%0d required=1/0/%0d",
                 k, illegal, outValid, illegalCount, exp_cnt);
      end
    end
    inValid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (illegal !== 1'b0 || illegalCount !== 8'd255) begin
      n_err++;
      $display("FAIL ill_sat ill=%b cnt=%0d required=0/255",
               illegal, illegalCount);
    end
  endtask

  task automatic test_reset_mid();
    outReady = 1'b0;
    send(32'h0000_0880, 32'h0, 32'hA5A5_A5A5);
    send(32'h0000_1102, 32'h0, 32'h5A5A_5A5A);
    n_cmp++;
    if (inReady !== 1'b0 || outValid !== 1'b1) begin
      n_err++;
      $display("FAIL rm_full rdy=%b v=%b required=0/1", inReady, outValid);
    end
    inValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outValid !== 1'b0) begin
      n_err++;
      $display("FAIL rm_async v=%b required=0", outValid);
    end
    sb.delete();
    exp_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (inReady !== 1'b1 || outValid !== 1'b0 || illegalCount !== '0) begin
      n_err++;
      $display("FAIL rm_release rdy=%b v=%b cnt=%0d required=1/0/0",
               inReady, outValid, illegalCount);
    end
    outReady = 1'b1;
    send(32'h0000_0843, 32'h0, 32'hF000_000F);
    inValid = 1'b0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_sll();
    test_srav();
    test_rotr();
    test_backpressure();
    test_random();
    test_illegal_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_decode_stage.md
# shift_decode_stage

Decode/issue stage directly upstream of the shift/rotate execution unit. It accepts raw MIPS R-type shift instructions with their register operands over a valid/ready handshake. It decodes funct/shamt/rs fields into the 3-bit shift opcode, operand and amount that the shift unit consumes, and presents them from a registered output with a 2-entry skid buffer. Illegal encodings are dropped, flagged and counted.

## Interface
- `ILL_CNT_W`, default 8: width of the saturating illegal-instruction counter.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `inst  in  32`: instruction word.
- `rsVal  in  32`: value of register rs.
- `rtVal  in  32`: value of register rt.
- `inValid  in  1`: upstream offers `inst`/`rsVal`/`rtVal`.
- `inReady  out  1`: stage can accept this cycle.
- `aShiftRotate  out  32`: operand to shift unit (rt value).
- `bShiftRotate  out  5`: shift amount.
- `opcodeShiftRotate  out  3`: shift opcode.
- `rdOut  out  5`: destination register (`inst[15:11]`).
- `outValid  out  1`: output fields valid.
- `outReady  in  1`: downstream consumes when high with `outValid`.
- `illegal  out  1`: one-cycle pulse when an illegal instruction is accepted.
- `illegalCount  out  ILL_CNT_W`: saturating count of accepted illegal instructions.

## Operation
- Opcode map: 000 rotate-left, 001 rotate-right, 010 sll, 011 srl, 111 sra. Codes 100–110 are never emitted.
- Every instruction must have `inst[31:26]==0`. Decode by `inst[5:0]`:
  - 000000 SLL: op 010, b=`inst[10:6]`; requires `inst[25:21]==0`.
  - 000010: `inst[25:21]==00000` gives SRL, op 011. `inst[25:21]==00001` gives ROTR, op 001. In both cases b=`inst[10:6]`.
  - 000011 SRA: op 111, b=`inst[10:6]`; requires `inst[25:21]==0`.
  - 000100 SLLV: op 010, b=`rsVal[4:0]`; requires `inst[10:6]==0`.
  - 000110: `inst[10:6]==00000` gives SRLV, op 011. `inst[10:6]==00001` gives ROTRV, op 001. In both cases b=`rsVal[4:0]`.
  - 000111 SRAV: op 111, b=`rsVal[4:0]`; requires `inst[10:6]==0`.
  - 000001 ROTL (team encoding): op 000, b=`inst[10:6]`; requires `inst[25:21]==0`.
  - 000101 ROTLV (team encoding): op 000, b=`rsVal[4:0]`; requires `inst[10:6]==0`.
  - Anything else is illegal.
- `aShiftRotate` = `rtVal` unmodified. Only `rsVal[4:0]` is used; upper bits are ignored.
- An instruction is accepted when `inValid && inReady`.
- An accepted legal instruction enters the buffer.
- An accepted illegal instruction is consumed but not buffered: `illegal` pulses the next cycle and `illegalCount` increments, saturating at all-ones.
- Buffer is two entries, output register plus skid register, and preserves order.
  - Accept while output empty, or output draining this cycle: data goes to the output register.
  - Accept while output is held (`outValid && !outReady`): data goes to the skid register.
  - When output drains and skid is full: skid moves to output.
- `inReady` = !skidValid, taken from a register. It never depends combinationally on `outReady`.
- Simultaneous accept and drain with skid full cannot occur, because `inReady`=0 in that case.
- Output fields hold stable while `outValid && !outReady`.

## Timing
- Latency: 1 cycle from accept to `outValid` when the buffer is empty.
- Throughput: 1 instruction per cycle with `outReady` held high.
- Reset (async assert, sync-clean deassert): `outValid`=0, skid empty, `inReady`=1 from reset, `illegal`=0, `illegalCount`=0, `aShiftRotate`=0, `bShiftRotate`=0, `opcodeShiftRotate`=3'b010, `rdOut`=0.
- Reset mid-operation discards both buffered entries. No partial output is presented after release.
- `illegal` is registered and asserts exactly one cycle per accepted illegal instruction. It asserts on consecutive cycles for back-to-back illegals.

## Configuration
- `SHIFT_DECODE_ROTATE_EN` defined: ROTR, ROTRV, ROTL and ROTLV decode as above; opcodes 000/001 can be emitted.
- `SHIFT_DECODE_ROTATE_EN` undefined: all four rotate encodings are illegal (dropped, flagged, counted); only 010/011/111 are emitted.

## Test plan
- Reset, then SLL (`inst`=0x00031080, shamt=2, rd=2) with `rtVal`=0x1 and `outReady`=1. Required next cycle: `outValid`=1, op 010, b=2, a=0x1, rdOut=2.
- SRAV with `rsVal`=0xFFFF_FFE3 and `rtVal`=0x8000_0000. Required: op 111, b=3 (upper rs bits ignored), a=0x8000_0000.
- ROTR (funct 000010, `inst[25:21]`=00001, shamt=4). Required: op 001, b=4 with the macro defined. With the macro undefined: no `outValid`, `illegal` pulse, `illegalCount`=1.
- Backpressure: `outReady`=0, send three valid instructions. Required: the first two are accepted and `inReady`=0 thereafter. Then set `outReady`=1: outputs appear in order with no loss or duplication.
- Illegal stream: send 300 instructions with `inst[31:26]`=0x08. Required: `outValid` stays 0, `illegal` pulses each cycle, and `illegalCount` saturates at 255 with `ILL_CNT_W`=8.
- Assert `rst_n` low with both buffer entries full. Required: `outValid`=0 immediately (asynchronous), `inReady`=1 once reset is released, `illegalCount`=0.
